adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per ADC sample period (even, >=2).
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 64, meaning clk cycles waited after power-up before sampling.
REQ-003 The block SHALL have parameter DISCARD, default 5, meaning ADC pipeline samples dropped after wake.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, meaning capture FIFO entries (power of 2).
REQ-005 The block SHALL have port clk, input, 1, the system clock; the block uses one clock.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1, the capture request level.
REQ-008 The block SHALL have port twos_comp, input, 1, where 1 means convert offset-binary to two's complement.
REQ-009 The block SHALL have port adc_data, input, 10, the ADC parallel output.
REQ-010 The block SHALL have port adc_clk, output, 1, the ADC sample clock.
REQ-011 The block SHALL have port adc_pwrdn, output, 1, ADC power-down (1 = powered down).
REQ-012 The block SHALL have port ovf_clr, input, 1, clearing the overflow flag.
REQ-013 The block SHALL have ports m_data (output, 10), m_valid (output, 1) and m_ready (input, 1), forming the sample stream to the bus side.
REQ-014 The block SHALL have port overflow, output, 1, a sticky dropped-sample flag.
REQ-015 The block SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, the FIFO occupancy.
REQ-016 The block SHALL have port running, output, 1, high in RUN state.

Function
REQ-017 The FSM SHALL have states IDLE, WAKE and RUN.
REQ-018 The IDLE-to-WAKE transition SHALL occur when enable=1; WAKE SHALL load wait counter = WAKE_CYCLES-1.
REQ-019 WAKE SHALL go to RUN when the wait counter reaches 0, and SHALL go to IDLE if enable=0 on any cycle.
REQ-020 RUN SHALL go to IDLE on the first cycle enable=0.
REQ-021 adc_pwrdn SHALL be 1 in IDLE and 0 in WAKE and RUN.
REQ-022 In RUN, div_cnt SHALL count 0..CLK_DIV-1 and wrap; adc_clk SHALL be 1 when div_cnt >= CLK_DIV/2, else 0.
REQ-023 Outside RUN, div_cnt SHALL be 0 and adc_clk SHALL be 0.
REQ-024 A sample edge SHALL be the RUN clk edge with div_cnt=CLK_DIV-1, which registers adc_data into the sample register.
REQ-025 The first DISCARD sample edges after entering RUN SHALL be dropped, tracked by a discard counter reloaded on each entry to RUN.
REQ-026 Conversion: if twos_comp=1, the stored word SHALL be {~adc_data[9], adc_data[8:0]}; otherwise it SHALL be stored unchanged; twos_comp SHALL be sampled at the sample edge.
REQ-027 A kept sample SHALL be written to the FIFO on the clk edge after its sample edge, including when that edge coincides with leaving RUN.
REQ-028 The FIFO SHALL be first-word-fall-through: m_valid=1 and m_data=head whenever fifo_level>0, so m_valid rises the cycle after the FIFO write.
REQ-029 A pop SHALL occur on an edge with m_valid=1 and m_ready=1; m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-030 If a write occurs with fifo_level=FIFO_DEPTH and no simultaneous pop, the sample SHALL be dropped, overflow SHALL be set to 1, and FIFO contents SHALL be unchanged.
REQ-031 A simultaneous write and pop when full SHALL accept both, leave level unchanged, and SHALL NOT set overflow.
REQ-032 A simultaneous write and pop at any level SHALL keep the level constant; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 ovf_clr=1 SHALL clear overflow, except that a set in the same cycle SHALL win.
REQ-034 FIFO contents SHALL be retained and remain readable in IDLE and WAKE.

Reset
REQ-035 On rst=1 at a clk edge, state SHALL become IDLE, and all counters and FIFO pointers SHALL be set to 0.
REQ-036 On rst=1 at a clk edge, outputs SHALL become adc_pwrdn=1, adc_clk=0, m_valid=0, m_data=0, overflow=0, fifo_level=0 and running=0.
REQ-037 rst SHALL override all other inputs, including mid-WAKE, mid-RUN or with a pending sample; any pending sample SHALL be discarded.

Verification
REQ-038 The bench SHALL check: enable=1 from reset -> adc_pwrdn falls next cycle, running rises 64 cycles later, adc_clk period is 4 clk at 50% duty.
REQ-039 The bench SHALL check: adc_data ramps 0,1,2.. per sample with m_ready=1 and twos_comp=0 -> first 5 samples are dropped, then m_data values are consecutive.
REQ-040 The bench SHALL check: adc_data=10'h000 and 10'h3FF with twos_comp=1 -> m_data=10'h200 and 10'h1FF.
REQ-041 The bench SHALL check: m_ready=0 for 20 samples -> fifo_level saturates at 16, overflow=1, and the 16 oldest samples are read back intact; ovf_clr then clears overflow.
REQ-042 The bench SHALL check: full FIFO with m_ready=1 held -> level stays 16 and overflow stays 0.
REQ-043 The bench SHALL check: enable drop mid-RUN and rst mid-WAKE -> IDLE next cycle with adc_pwrdn=1 and adc_clk=0; the rst case also gives fifo_level=0.

Source files
------------

// File: rtl/adc_capture.sv
// ADC capture: powers up a parallel ADC, generates its sample clock, and streams kept samples out through a FIFO.
// Latency: a sample reaches the FIFO one clk after its sample edge, and m_valid rises on the following cycle.
// Backpressure: m_valid/m_ready handshake. When the FIFO is full and there is no pop, the new sample is dropped and overflow is set.

// Show-ahead FIFO: the head word is presented while the FIFO is non-empty.
// Latency: a word written on one edge is visible on o_rd_dat after that edge.
// Backpressure: i_rd_rdy pops the head. A write into a full FIFO is refused unless a pop happens in the same cycle.
module adc_capture_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_vld,
  input  logic [DW-1:0]            i_wr_dat,
  output logic                     o_rd_vld,
  output logic [DW-1:0]            o_rd_dat,
  input  logic                     i_rd_rdy,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && i_rd_rdy;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign w_push  = i_wr_vld && (!w_full || w_pop);
  assign o_drop  = i_wr_vld && w_full && !w_pop;

  assign o_rd_vld = !w_empty;
  assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level  = r_level;

  // Pointers wrap naturally because DEPTH is a power of two; the level only changes on an unpaired push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array. It is not reset, because the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= i_wr_dat;
  end

endmodule

module adc_capture #(
  parameter int CLK_DIV     = 4,
  parameter int WAKE_CYCLES = 64,
  parameter int DISCARD     = 5,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          twos_comp,
  input  logic [9:0]                    adc_data,
  output logic                          adc_clk,
  output logic                          adc_pwrdn,
  input  logic                          ovf_clr,
  output logic [9:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WAIT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int DISC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAKE_CYCLES - 1);
  localparam logic [DISC_W-1:0] DISC_LOAD = DISC_W'(DISCARD);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [DIV_W-1:0]  r_div;
  logic [DISC_W-1:0] r_disc;
  logic [9:0]        r_sample;
  logic              r_pend;
  logic              r_overflow;

  logic       w_enter_run;
  logic       w_sample_edge;
  logic [9:0] w_conv;
  logic       w_drop;

  // RUN is entered on the edge where WAKE has finished counting down while enable is still held.
  assign w_enter_run   = (r_state == S_WAKE) && enable && (r_wait == '0);
  assign w_sample_edge = (r_state == S_RUN) && (r_div == DIV_LAST);
  // Inverting the MSB turns an offset-binary code into two's complement.
  assign w_conv        = twos_comp ? {~adc_data[9], adc_data[8:0]} : adc_data;

  assign adc_pwrdn = (r_state == S_IDLE);
  assign running   = (r_state == S_RUN);
  assign adc_clk   = running && (r_div >= DIV_HALF);
  assign overflow  = r_overflow;

  // Power sequencing FSM: leave IDLE on enable, wait out the ADC wake time, and drop straight back to IDLE when enable falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_WAKE;
            r_wait  <= WAIT_LOAD;
          end
        end
        S_WAKE: begin
          if (!enable)             r_state <= S_IDLE;
          else if (r_wait == '0)   r_state <= S_RUN;
          else                     r_wait  <= r_wait - WAIT_W'(1);
        end
        S_RUN: begin
          if (!enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sample clock divider. It is held at zero outside RUN, so every RUN entry starts with adc_clk low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if ((r_state == S_RUN) && enable) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end else begin
      r_div <= '0;
    end
  end

  // Capture at each sample edge. The ADC pipeline warm-up samples are skipped, and a kept sample raises a one-cycle write request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '0;
      r_pend   <= 1'b0;
      r_disc   <= '0;
    end else begin
      r_pend <= 1'b0;
      if (w_enter_run) begin
        r_disc <= DISC_LOAD;
      end else if (w_sample_edge) begin
        if (r_disc != '0) begin
          r_disc <= r_disc - DISC_W'(1);
        end else begin
          r_sample <= w_conv;
          r_pend   <= 1'b1;
        end
      end
    end
  end

  // Sticky overflow flag. When a drop and a clear happen in the same cycle, the drop wins.
  always_ff @(posedge clk) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  adc_capture_fifo #(
    .DW    (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (r_pend),
    .i_wr_dat (r_sample),
    .o_rd_vld (m_valid),
    .o_rd_dat (m_data),
    .i_rd_rdy (m_ready),
    .o_level  (fifo_level),
    .o_drop   (w_drop)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with the default parameters (CLK_DIV=4, WAKE=64, DISCARD=5, DEPTH=16).
// Inputs are driven and outputs sampled 1 ns after each rising clk edge.
// Every expected value below is hand-derived from the block's requirements.
module tb_adc_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       twos_comp = 1'b0;
  logic [9:0] adc_data = 10'd0;
  logic       adc_clk;
  logic       adc_pwrdn;
  logic       ovf_clr = 1'b0;
  logic [9:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       overflow;
  logic [4:0] fifo_level;
  logic       running;

  int passed = 0;
  int total  = 0;

  adc_capture dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .twos_comp  (twos_comp),
    .adc_data   (adc_data),
    .adc_clk    (adc_clk),
    .adc_pwrdn  (adc_pwrdn),
    .ovf_clr    (ovf_clr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    twos_comp = 1'b0; adc_data = 10'd0;
    step(); step();
    rst = 1'b0;
  endtask

  // Steps until n falling edges of adc_clk (one per sample edge) have been seen; optionally ramps adc_data after each one.
  task automatic wait_samples(input int n, input bit ramp);
    int   falls;
    int   cyc;
    logic prev;
    falls = 0; cyc = 0; prev = adc_clk;
    while (falls < n && cyc < n * 4 + 40) begin
      step(); cyc++;
      if (prev && !adc_clk) begin
        falls++;
        if (ramp) adc_data = adc_data + 10'd1;
      end
      prev = adc_clk;
    end
    if (falls < n) begin
      total++;
      $display("FAIL wait_samples: saw %0d sample edges, required %0d", falls, n);
    end
  endtask

  task automatic go_run();
    int cyc;
    enable = 1'b1; cyc = 0;
    while (running !== 1'b1 && cyc < 100) begin step(); cyc++; end
    total++;
    if (running !== 1'b1) $display("FAIL go_run: running=%b after %0d cycles, required 1", running, cyc);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (adc_pwrdn !== 1'b1) $display("FAIL rst_pwrdn: got %b required 1", adc_pwrdn); else passed++;
    total++; if (adc_clk !== 1'b0) $display("FAIL rst_adc_clk: got %b required 0", adc_clk); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b required 0", m_valid); else passed++;
    total++; if (m_data !== 10'h000) $display("FAIL rst_m_data: got %h required 000", m_data); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", overflow); else passed++;
    total++; if (fifo_level !== 5'd0) $display("FAIL rst_level: got %0d required 0", fifo_level); else passed++;
    total++; if (running !== 1'b0) $display("FAIL rst_running: got %b required 0", running); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_wake();
    int cyc;
    int errs;
    int highs;
    logic exp_clk;
    do_reset();
    enable = 1'b1;
    step();
    total++; if (adc_pwrdn !== 1'b0) $display("FAIL wake_pwrdn: got %b required 0", adc_pwrdn); else passed++;
    cyc = 0;
    while (running !== 1'b1 && cyc < 200) begin step(); cyc++; end
    total++; if (cyc != 64) $display("FAIL wake_time: running rose after %0d cycles, required 64", cyc); else passed++;
    errs = 0; highs = 0;
    for (int k = 0; k < 8; k++) begin
      exp_clk = ((k % 4) >= 2);
      if (adc_clk !== exp_clk) errs++;
      if (adc_clk === 1'b1) highs++;
      step();
    end
    total++; if (errs != 0) $display("FAIL adc_clk_pattern: %0d cycles differ from 0011 0011, required 0", errs); else passed++;
    total++; if (highs != 4) $display("FAIL adc_clk_duty: %0d high cycles in 8, required 4", highs); else passed++;
  endtask

  task automatic test_ramp();
    logic [9:0] vals [6];
    int   got;
    int   cyc;
    int   errs;
    logic prev;
    do_reset();
    m_ready = 1'b1;
    go_run();
    got = 0; cyc = 0; prev = adc_clk;
    while (got < 6 && cyc < 200) begin
      if (m_valid === 1'b1) begin vals[got] = m_data; got++; end
      step(); cyc++;
      if (prev && !adc_clk) adc_data = adc_data + 10'd1;
      prev = adc_clk;
    end
    total++; if (got != 6) $display("FAIL ramp_count: got %0d words required 6", got); else passed++;
    total++; if (got < 1 || vals[0] !== 10'd5) $display("FAIL ramp_first: got %h required 005", vals[0]); else passed++;
    errs = 0;
    for (int i = 1; i < got; i++) if (vals[i] !== 10'd5 + 10'(i)) errs++;
    total++; if (errs != 0) $display("FAIL ramp_consecutive: %0d words out of sequence, required 0", errs); else passed++;
  endtask

  task automatic test_twos();
    do_reset();
    twos_comp = 1'b1;
    go_run();
    wait_samples(6, 1'b0);
    adc_data = 10'h3FF;
    wait_samples(1, 1'b0);
    step();
    total++; if (fifo_level !== 5'd2) $display("FAIL twos_level: got %0d required 2", fifo_level); else passed++;
    total++; if (m_data !== 10'h200) $display("FAIL twos_zero: got %h required 200", m_data); else passed++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    total++; if (m_data !== 10'h1FF) $display("FAIL twos_full: got %h required 1FF", m_data); else passed++;
  endtask

  task automatic test_overflow();
    int errs;
    do_reset();
    go_run();
    wait_samples(25, 1'b1);
    enable = 1'b0;
    step(); step();
    total++; if (fifo_level !== 5'd16) $display("FAIL ovf_level: got %0d required 16", fifo_level); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b required 1", overflow); else passed++;
    total++; if (adc_pwrdn !== 1'b1) $display("FAIL ovf_idle: pwrdn %b required 1", adc_pwrdn); else passed++;
    errs = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (m_valid !== 1'b1 || m_data !== 10'd5 + 10'(i)) errs++;
      step();
    end
    m_ready = 1'b0;
    total++; if (errs != 0) $display("FAIL ovf_readback: %0d words wrong, required 0", errs); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL ovf_drained: m_valid %b required 0", m_valid); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow); else passed++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow); else passed++;
  endtask

  task automatic test_full_stream();
    do_reset();
    go_run();
    wait_samples(21, 1'b1);
    wait_samples(1, 1'b1);
    total++; if (fifo_level !== 5'd16) $display("FAIL full_before: got %0d required 16", fifo_level); else passed++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    total++; if (fifo_level !== 5'd16) $display("FAIL full_level: got %0d required 16", fifo_level); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL full_no_ovf: got %b required 0", overflow); else passed++;
    total++; if (m_data !== 10'd6) $display("FAIL full_head: got %h required 006", m_data); else passed++;
  endtask

  task automatic test_exit();
    do_reset();
    go_run();
    wait_samples(7, 1'b0);
    step(); step();
    total++; if (adc_clk !== 1'b1) $display("FAIL exit_pre_clk: got %b required 1", adc_clk); else passed++;
    enable = 1'b0;
    step();
    total++; if (running !== 1'b0) $display("FAIL exit_running: got %b required 0", running); else passed++;
    total++; if (adc_pwrdn !== 1'b1) $display("FAIL exit_pwrdn: got %b required 1", adc_pwrdn); else passed++;
    total++; if (adc_clk !== 1'b0) $display("FAIL exit_adc_clk: got %b required 0", adc_clk); else passed++;
    total++; if (fifo_level !== 5'd2) $display("FAIL exit_retained: level %0d required 2", fifo_level); else passed++;
    enable = 1'b1;
    repeat (10) step();
    total++; if (adc_pwrdn !== 1'b0 || running !== 1'b0) $display("FAIL wake_mid: pwrdn %b running %b required 0 0", adc_pwrdn, running); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    total++; if (adc_pwrdn !== 1'b1) $display("FAIL rstwake_pwrdn: got %b required 1", adc_pwrdn); else passed++;
    total++; if (adc_clk !== 1'b0) $display("FAIL rstwake_adc_clk: got %b required 0", adc_clk); else passed++;
    total++; if (fifo_level !== 5'd0) $display("FAIL rstwake_level: got %0d required 0", fifo_level); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL rstwake_valid: got %b required 0", m_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_wake();
    test_ramp();
    test_twos();
    test_overflow();
    test_full_stream();
    test_exit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
